// File: rtl/led_seg_output_if.sv
// CPU IO write bus as seen by the LED / seven-segment output port.
// The address decoder drives the store strobe, address and data.
interface led_seg_output_if;
  logic        ledCtrl;
  logic [31:0] address;
  logic [31:0] writeData;

  modport master (output ledCtrl, address, writeData);
  modport slave  (input  ledCtrl, address, writeData);
endinterface

// File: rtl/led_seg_output.sv
// Write-only IO peripheral: latches CPU stores into LED / hex / mask holding registers
// and scans an 8-digit multiplexed seven-segment display one digit per SCAN_DIV cycles.
module led_seg_output #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  led_seg_output_if.slave   bus,
  output logic [15:0]       led,
  output logic [7:0]        segEn,
  output logic [7:0]        segOut
);
  localparam logic [31:0] ADDR_LED    = 32'hffff_ffc1;
  localparam logic [31:0] ADDR_LED_HI = 32'hffff_ffc3;
  localparam logic [31:0] ADDR_HEX    = 32'hffff_ffc5;
  localparam logic [31:0] ADDR_MASK   = 32'hffff_ffc7;

  logic [15:0]      led_reg;
  logic [31:0]      hex_reg;
  logic [7:0]       mask_reg;
  logic [CNT_W-1:0] prescaler;
  logic [2:0]       idx;
  logic             wrap;
  logic [3:0]       nibble;
  logic [6:0]       seg7;

  assign wrap   = (prescaler == CNT_W'(SCAN_DIV - 1));
  assign nibble = hex_reg[{idx, 2'b00} +: 4];

  // Segment pattern {g,f,e,d,c,b,a} for the currently scanned digit.
  always_comb begin
    seg7 = 7'h00;
    case (nibble)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg   <= '0;
      hex_reg   <= '0;
      mask_reg  <= '0;
      prescaler <= '0;
      idx       <= '0;
      led       <= '0;
      segEn     <= '0;
      segOut    <= '0;
    end else begin
      if (bus.ledCtrl) begin
        case (bus.address)
          ADDR_LED:    led_reg       <= bus.writeData[15:0];
          ADDR_LED_HI: led_reg[15:8] <= bus.writeData[7:0];
          ADDR_HEX:    hex_reg       <= bus.writeData;
          ADDR_MASK:   mask_reg      <= bus.writeData[7:0];
          default:     ;
        endcase
      end

      // Every digit owns a full slot, lit or blanked, so the scan period is fixed.
      if (wrap) begin
        prescaler <= '0;
        idx       <= idx + 3'd1;
      end else begin
        prescaler <= prescaler + CNT_W'(1);
      end

      led <= led_reg;
      if (mask_reg[idx]) begin
        segEn  <= 8'b1 << idx;
        segOut <= {1'b0, seg7};
      end else begin
        segEn  <= '0;
        segOut <= '0;
      end
    end
  end
endmodule

// File: tb/tb_led_seg_output.sv
// Bench for led_seg_output: directed steps then random stores, every cycle compared
// against a reference model built from the register map and scan timing.
module tb_led_seg_output;
  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic [7:0]  segEn;
  logic [7:0]  segOut;

  led_seg_output_if bus ();

  led_seg_output #(.SCAN_DIV(SCAN_DIV), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .led    (led),
    .segEn  (segEn),
    .segOut (segOut)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [6:0]  hex7_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_led_reg;
  logic [31:0] m_hex;
  logic [7:0]  m_mask;
  int          k;
  logic [15:0] exp_led;
  logic [7:0]  exp_seg_en;
  logic [7:0]  exp_seg_out;

  int n_checks = 0;
  int n_errors = 0;

  // Drive one cycle of bus inputs, advance the model across the edge, compare outputs.
  task automatic tick(input logic r, input logic c, input logic [31:0] a, input logic [31:0] d);
    int          slot;
    logic [3:0]  nib;
    rst           = r;
    bus.ledCtrl   = c;
    bus.address   = a;
    bus.writeData = d;
    @(posedge clk);
    if (r) begin
      m_led_reg   = '0;
      m_hex       = '0;
      m_mask      = '0;
      k           = 0;
      exp_led     = '0;
      exp_seg_en  = '0;
      exp_seg_out = '0;
    end else begin
      k++;
      slot    = ((k - 1) / SCAN_DIV) % 8;
      exp_led = m_led_reg;
      if (m_mask[slot]) begin
        nib         = m_hex[slot*4 +: 4];
        exp_seg_en  = 8'(1 << slot);
        exp_seg_out = {1'b0, hex7_tab[nib]};
      end else begin
        exp_seg_en  = '0;
        exp_seg_out = '0;
      end
      if (c) begin
        case (a)
          32'hffff_ffc1: m_led_reg       = d[15:0];
          32'hffff_ffc3: m_led_reg[15:8] = d[7:0];
          32'hffff_ffc5: m_hex           = d;
          32'hffff_ffc7: m_mask          = d[7:0];
          default: ;
        endcase
      end
    end
    #1;
    n_checks++;
    assert (led === exp_led) else begin
      n_errors++;
      $error("FAIL led k=%0d got %h exp %h", k, led, exp_led);
    end
    n_checks++;
    assert (segEn === exp_seg_en) else begin
      n_errors++;
      $error("FAIL segEn k=%0d got %h exp %h", k, segEn, exp_seg_en);
    end
    n_checks++;
    assert (segOut === exp_seg_out) else begin
      n_errors++;
      $error("FAIL segOut k=%0d got %h exp %h", k, segOut, exp_seg_out);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] addr_pool [6] = '{32'hffff_ffc1, 32'hffff_ffc3, 32'hffff_ffc5,
                                  32'hffff_ffc7, 32'hffff_ffc9, 32'hffff_ffc0};
    rst = 1'b1;
    bus.ledCtrl = 1'b0;
    bus.address = '0;
    bus.writeData = '0;

    // reset held with a store pending
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 32'hffff_ffc1, 32'h0000_FFFF);

    // LED full write then upper-byte write
    tick(1'b0, 1'b1, 32'hffff_ffc1, 32'h0000_A5C3);
    tick(1'b0, 1'b1, 32'hffff_ffc3, 32'h0000_0012);
    idle(2);

    // unmapped address and strobe-low stores are ignored
    tick(1'b0, 1'b1, 32'hffff_ffc9, 32'hFFFF_FFFF);
    tick(1'b0, 1'b0, 32'hffff_ffc1, 32'h0000_1234);
    tick(1'b0, 1'b0, 32'hffff_ffc5, 32'h1234_5678);
    idle(2);

    // all digits lit, full scan plus wrap
    tick(1'b0, 1'b1, 32'hffff_ffc5, 32'h7654_3210);
    tick(1'b0, 1'b1, 32'hffff_ffc7, 32'h0000_00FF);
    idle(40);

    // only digit 0 lit
    tick(1'b0, 1'b1, 32'hffff_ffc5, 32'h0000_00EF);
    tick(1'b0, 1'b1, 32'hffff_ffc7, 32'h0000_0001);
    idle(70);

    // reset mid-scan once digit 5 is being scanned
    for (int i = 0; i < 40 && (((k / SCAN_DIV) % 8) != 5); i++) idle(1);
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, 32'hffff_ffc7, 32'h0000_00FF);
    idle(20);

    // random stores over mapped and unmapped addresses, occasional reset
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 60) == 0,
           1'($urandom_range(0, 1)),
           addr_pool[$urandom_range(0, 5)],
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
